// File: rtl/key_conditioner_pkg.sv
// Shared types and helpers for the pushbutton conditioner.
package key_conditioner_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    HELD_WAIT   = 2'd1,
    HELD_REPEAT = 2'd2
  } key_state_t;

  // Bits needed to hold every value 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One button channel: 2-flop synchroniser, debounce, edge pulses and hold-to-repeat.
module key_channel
  import key_conditioner_pkg::*;
#(
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int unsigned DEB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = cnt_width(REP_MAX);

  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [REP_W-1:0] DELAY_V  = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] PERIOD_V = REP_W'(REPEAT_PERIOD);
  localparam logic [REP_W-1:0] REP_SAT  = REP_W'(REP_MAX);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  key_state_t       state_q, state_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
  logic             press_q, release_q, repeat_q, repeat_d;
  logic             press_edge, release_edge;

  always_comb begin
    level_d   = level_q;
    deb_cnt_d = '0;
    if (sync_q[1] != level_q) begin
      if (deb_cnt_q >= DEB_MAX) begin
        level_d   = ~level_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  assign press_edge   = level_d & ~level_q;
  assign release_edge = ~level_d & level_q;
  assign rep_inc      = (rep_cnt_q >= REP_SAT) ? rep_cnt_q : rep_cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    repeat_d  = 1'b0;
    case (state_q)
      RELEASED: begin
        rep_cnt_d = '0;
        if (press_edge) state_d = HELD_WAIT;
      end
      HELD_WAIT: begin
        // A zero delay parks the channel here: held, but never repeating.
        if (REPEAT_DELAY != 0) begin
          if (rep_inc == DELAY_V) begin
            state_d   = HELD_REPEAT;
            rep_cnt_d = '0;
            repeat_d  = 1'b1;
          end else begin
            rep_cnt_d = rep_inc;
          end
        end
      end
      HELD_REPEAT: begin
        if (rep_inc == PERIOD_V) begin
          rep_cnt_d = '0;
          repeat_d  = 1'b1;
        end else begin
          rep_cnt_d = rep_inc;
        end
      end
      default: begin
        state_d   = RELEASED;
        rep_cnt_d = '0;
      end
    endcase
    if (release_edge) begin
      state_d   = RELEASED;
      rep_cnt_d = '0;
      repeat_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      level_q   <= 1'b0;
      deb_cnt_q <= '0;
      state_q   <= RELEASED;
      rep_cnt_q <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], raw_i ^ ACTIVE_LOW};
      level_q   <= level_d;
      deb_cnt_q <= deb_cnt_d;
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
      press_q   <= press_edge;
      release_q <= release_edge;
      repeat_q  <= repeat_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_conditioner.sv
// NUM_KEYS independent button channels plus a combined press strobe for the control FSM.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 2,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                any_press
);

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
      key_channel #(
        .ACTIVE_LOW     (ACTIVE_LOW),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_ch (
        .clk_i    (Clk),
        .rst_i    (Reset),
        .raw_i    (key_raw[gi]),
        .level_o  (key_level[gi]),
        .press_o  (key_press[gi]),
        .release_o(key_release[gi]),
        .repeat_o (key_repeat[gi])
      );
    end
  endgenerate

  // OR of registered pulses, so it lines up with key_press in the same cycle.
  assign any_press = |key_press;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with a history-based reference model checked every cycle.
module tb_key_conditioner;

  localparam int NK   = 2;
  localparam bit AL   = 1'b1;
  localparam int D    = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_raw = '1;
  logic [NK-1:0] level, press, rel, rep;
  logic          anyp;

  always #5 clk = ~clk;

  key_conditioner #(
    .NUM_KEYS(NK), .ACTIVE_LOW(AL), .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .Clk(clk), .Reset(rst), .key_raw(key_raw), .key_level(level),
    .key_press(press), .key_release(rel), .key_repeat(rep), .any_press(anyp)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = -1;

  bit rst_h [MAXC];
  bit raw_h [NK][MAXC];
  bit s_h   [NK][MAXC];
  bit m_lvl [NK];
  int m_pcyc[NK];
  logic [NK-1:0] e_level = '0, e_press = '0, e_rel = '0, e_rep = '0;

  initial begin
    for (int k = 0; k < NK; k++) begin
      m_lvl[k]  = 1'b0;
      m_pcyc[k] = -1;
    end
  end

  // Model: level flips once the synchronised value has disagreed with it on D+1
  // consecutive non-reset edges; repeats fall on press+RD+m*RP while still held.
  always @(posedge clk) begin : model
    int n;
    bit tog;
    cyc = cyc + 1;
    n   = cyc;
    if (n < MAXC) begin
      rst_h[n] = rst;
      for (int k = 0; k < NK; k++) begin
        raw_h[k][n] = key_raw[k] ^ AL;
        s_h[k][n]   = (n >= 2 && !rst_h[n-1] && !rst_h[n-2]) ? raw_h[k][n-2] : 1'b0;
        e_press[k]  = 1'b0;
        e_rel[k]    = 1'b0;
        e_rep[k]    = 1'b0;
        if (rst) begin
          m_lvl[k]  = 1'b0;
          m_pcyc[k] = -1;
        end else begin
          tog = (n >= D);
          for (int j = 0; j <= D && tog; j++) begin
            if (s_h[k][n-j] == m_lvl[k]) tog = 1'b0;
            if (j > 0 && rst_h[n-j]) tog = 1'b0;
          end
          if (tog) begin
            m_lvl[k] = ~m_lvl[k];
            if (m_lvl[k]) begin
              e_press[k] = 1'b1;
              m_pcyc[k]  = n;
            end else begin
              e_rel[k]  = 1'b1;
              m_pcyc[k] = -1;
            end
          end else if (m_lvl[k] && m_pcyc[k] >= 0 && RD != 0 &&
                       n - m_pcyc[k] >= RD && (n - m_pcyc[k] - RD) % RP == 0) begin
            e_rep[k] = 1'b1;
          end
        end
        e_level[k] = m_lvl[k];
      end
    end
  end

  always @(negedge clk) begin
    if (cyc >= 0) begin
      tests++;
      if ({level, press, rel, rep, anyp} !== {e_level, e_press, e_rel, e_rep, |e_press}) begin
        fails++;
        $display("FAIL cycle_%0d: got level=%b press=%b rel=%b rep=%b any=%b want level=%b press=%b rel=%b rep=%b any=%b",
                 cyc, level, press, rel, rep, anyp, e_level, e_press, e_rel, e_rep, |e_press);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end else begin
      $display("[TB] %s: got %0d ok", name, got);
    end
  endtask

  // which: 0 press, 1 release, 2 repeat. at = -1 when the budget expires.
  task automatic wait_pulse(input int which, input int key, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(negedge clk);
      case (which)
        0:       if (press[key]) at = cyc;
        1:       if (rel[key])   at = cyc;
        default: if (rep[key])   at = cyc;
      endcase
    end
  endtask

  initial begin
    int k, at, p, cnt, ri, r1;
    int exp_rep[7];
    exp_rep = '{10, 13, 16, 19, 22, 25, 28};

    rst = 1'b1;
    key_raw = 2'b11;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({level, press, rel, rep, anyp}), 0);
    rst = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      cnt += $countones({press, rel, rep});
    end
    check("idle_after_reset_pulses", cnt, 0);

    key_raw[0] = 1'b0;
    k = cyc + 1;
    wait_pulse(0, 0, 20, at);
    check("press0_cycle", at, k + 6);
    check("press0_any_press", int'(anyp), 1);
    check("press0_level", int'(level[0]), 1);
    check("press0_ch1_level", int'(level[1]), 0);
    @(negedge clk);
    check("press0_single_pulse", int'(press[0]), 0);
    key_raw[0] = 1'b1;
    k = cyc + 1;
    wait_pulse(1, 0, 20, at);
    check("release0_cycle", at, k + 6);

    repeat (5) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) key_raw[0] = ~key_raw[0];
      @(negedge clk);
      cnt += int'(press[0]) + int'(rel[0]) + int'(level[0]);
    end
    key_raw[0] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      cnt += int'(press[0]) + int'(rel[0]) + int'(level[0]);
    end
    check("bounce_no_activity", cnt, 0);

    key_raw[1] = 1'b0;
    k = cyc + 1;
    wait_pulse(0, 1, 20, p);
    check("press1_cycle", p, k + 6);
    ri = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (rep[1]) begin
        if (ri < 7) check($sformatf("repeat1_%0d_offset", ri), cyc - p, exp_rep[ri]);
        ri++;
      end
    end
    check("repeat1_count", ri, 7);
    key_raw[1] = 1'b1;
    k = cyc + 1;
    wait_pulse(1, 1, 20, at);
    check("release1_cycle", at, k + 6);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      cnt += int'(rep[1]) + int'(rel[1]);
    end
    check("after_release1_quiet", cnt, 0);

    key_raw = 2'b00;
    k = cyc + 1;
    wait_pulse(0, 0, 20, at);
    check("simul_press_cycle", at, k + 6);
    check("simul_press_both", int'(press), 3);
    check("simul_any_press", int'(anyp), 1);
    @(negedge clk);
    check("simul_any_press_once", int'(anyp), 0);
    key_raw = 2'b11;
    wait_pulse(1, 0, 20, at);
    repeat (5) @(negedge clk);

    key_raw[1] = 1'b0;
    wait_pulse(0, 1, 20, p);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_outputs", int'({level, press, rel, rep, anyp}), 0);
    rst = 1'b0;
    k = cyc + 1;
    wait_pulse(0, 1, 20, at);
    check("midreset_press_cycle", at, k + 6);
    wait_pulse(2, 1, 20, r1);
    check("midreset_first_repeat", r1 - at, 10);
    key_raw[1] = 1'b1;
    wait_pulse(1, 1, 20, at);
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failed so far %0d", fails);
    $fatal(1);
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Parametrised pushbutton input conditioner for the MNIST inference top level on the DE10-Lite. It synchronises, debounces and edge-detects NUM_KEYS raw button inputs (KEY is active-low on the board), adds optional hold-to-repeat, and presents clean single-cycle press, release and repeat pulses to the control FSM. It replaces ad-hoc direct use of KEY levels for reset, start and image stepping.

## Interface
Parameters:
- NUM_KEYS, 2: number of independent button channels.
- ACTIVE_LOW, 1: 1 means a raw 0 is pressed; 0 means a raw 1 is pressed.
- DEBOUNCE_CYCLES, 500000: consecutive cycles a new synchronised level must hold before it is accepted; minimum 1.
- REPEAT_DELAY, 25000000: cycles from the press pulse to the first repeat pulse; 0 disables repeat.
- REPEAT_PERIOD, 5000000: cycles between later repeat pulses; minimum 1.

Ports:
- Clk, in, 1: system clock (MAX10_CLK1_50).
- Reset, in, 1: synchronous, active-high reset.
- key_raw, in, NUM_KEYS: asynchronous raw button inputs.
- key_level, out, NUM_KEYS: debounced level; 1 means pressed.
- key_press, out, NUM_KEYS: one-cycle pulse on the accepted press.
- key_release, out, NUM_KEYS: one-cycle pulse on the accepted release.
- key_repeat, out, NUM_KEYS: one-cycle auto-repeat pulse while held.
- any_press, out, 1: OR of key_press.

## Operation
- Each channel has its own state. Channels share no state and are fully independent.
- Normalisation: each raw bit is XORed with ACTIVE_LOW, so 1 means pressed. The result goes through a 2-flop synchroniser.
- Debounce:
  - The counter increments on every edge where the synchronised level differs from key_level.
  - The counter clears on any edge where the two are equal.
  - When the counter reaches DEBOUNCE_CYCLES, key_level toggles and the counter clears.
- Pulses: key_press is asserted in exactly the cycle key_level goes 0→1. key_release is asserted in exactly the cycle key_level goes 1→0.
- Per-channel FSM states: RELEASED, HELD_WAIT, HELD_REPEAT.
  - RELEASED → HELD_WAIT on the accepted press. The repeat counter loads 0.
  - HELD_WAIT → HELD_REPEAT when the repeat counter reaches REPEAT_DELAY. A key_repeat pulse fires and the counter clears.
  - HELD_REPEAT: key_repeat fires each time the counter reaches REPEAT_PERIOD, then the counter clears.
  - Any state → RELEASED on the accepted release. The counter clears and no repeat fires in that cycle.
  - If REPEAT_DELAY is 0, the FSM stays in HELD_WAIT and never repeats.
- Glitches: a bounce shorter than DEBOUNCE_CYCLES produces no pulse and leaves key_level unchanged.
- Counter widths are $clog2(param+1) bits. Counters saturate and never wrap.

## Timing
- Reset values:
  - Synchroniser flops: 0 (released).
  - key_level: 0.
  - All pulses: 0.
  - FSM: RELEASED.
  - Counters: 0.
- Reset has priority over every other event, including mid-debounce and mid-repeat. The state after reset is the same as at power-up.
- A key held through reset is accepted as a fresh press after the full latency once Reset deasserts.
- Press latency: raw held stable from clock edge k gives key_level = 1 and key_press = 1 after edge k+2+DEBOUNCE_CYCLES. Release latency is the same.
- First repeat pulse: exactly REPEAT_DELAY cycles after the key_press cycle.
- Later repeats: every REPEAT_PERIOD cycles.
- key_press and key_repeat never assert in the same cycle.
- key_release and key_repeat never assert in the same cycle; release wins.
- Outputs are registered. No combinational path exists from key_raw to any output.

## Structure
- Package key_conditioner_pkg holds:
  - the key_state_t enum (RELEASED, HELD_WAIT, HELD_REPEAT);
  - a helper function for counter widths.
- Sub-module key_channel implements one channel: synchroniser, debounce counter, FSM and repeat counter.
- key_conditioner instantiates NUM_KEYS copies of key_channel in a generate loop and forms any_press.

## Test plan
All scenarios use NUM_KEYS=2, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset: hold Reset for 3 cycles with key_raw=2'b11 → all outputs 0. No pulse follows for 20 cycles.
- Clean press: drive key_raw[0]=0 from edge k →
  - key_level[0]=1 and a single key_press[0] pulse at edge k+6;
  - any_press=1 in that same cycle;
  - channel 1 unaffected.
- Bounce: toggle key_raw[0] every 2 cycles for 20 cycles, then return it to 1 → no pulse and key_level[0] stays 0.
- Repeat: hold key 1 for 30 cycles after its press pulse → key_repeat[1] at press+10, +13, +16, +19, +22, +25, +28. On release, one key_release[1] pulse 6 cycles after the raw edge, then no more repeats.
- Simultaneous: press both keys on the same edge → both key_press bits pulse in the same cycle and any_press=1 for exactly one cycle.
- Reset mid-operation: assert Reset 5 cycles into repeat hold with the key still held → outputs go to 0 the next cycle. key_press fires 6 cycles after Reset deasserts, and the first repeat comes 10 cycles after that.
